// File: rtl/sd_cmd_sequencer_if.sv
// sd_cmd_sequencer_if: host command bus and SPI byte-engine link.
// slave = sequencer view, master = register file / engine view.
`timescale 1ns/1ps
interface sd_cmd_sequencer_if;
  logic        Start;
  logic        InitReq;
  logic [5:0]  CmdIndex;
  logic [31:0] CmdArg;
  logic [6:0]  CmdCrc;
  logic [2:0]  RespBytes;
  logic        Busy;
  logic        Done;
  logic        Timeout;
  logic [7:0]  RespR1;
  logic [31:0] RespData;
  logic        ByteStrobe;
  logic [7:0]  RxByte;
  logic [7:0]  TxByte;
  logic        SpiEnable;
  logic        SpiEnableCS;

  modport slave (
    input  Start, InitReq, CmdIndex, CmdArg, CmdCrc, RespBytes,
    input  ByteStrobe, RxByte,
    output Busy, Done, Timeout, RespR1, RespData,
    output TxByte, SpiEnable, SpiEnableCS
  );

  modport master (
    output Start, InitReq, CmdIndex, CmdArg, CmdCrc, RespBytes,
    output ByteStrobe, RxByte,
    input  Busy, Done, Timeout, RespR1, RespData,
    input  TxByte, SpiEnable, SpiEnableCS
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: drives the SPI byte engine through SD SPI-mode
// init bursts and command/R1/trailing-byte transactions.
// Ports: MasterCLK, MasterRST_n (async, active-low), bus (slave):
//   host  Start/InitReq/CmdIndex/CmdArg/CmdCrc/RespBytes in,
//         Busy/Done/Timeout/RespR1/RespData out
//   engine ByteStrobe/RxByte in, TxByte/SpiEnable/SpiEnableCS out
`timescale 1ns/1ps
module sd_cmd_sequencer #(
  parameter int INIT_BYTES  = 10,
  parameter int NCR_MAX     = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               MasterCLK,
  input logic               MasterRST_n,
  sd_cmd_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, INIT, PRE, CMD, POLL,
    DATA, POST, POST_INIT, DONE
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE, TAG_POLL, TAG_DATA
  } tag_e;

  state_e state_q;
  tag_e   tag0_q;
  tag_e   tag1_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_q;
  logic                   tick;

  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic [2:0]  nresp_q;
  logic [3:0]  cnt_q;
  logic [7:0]  cmd_byte;

  logic        busy_q;
  logic        done_q;
  logic        to_q;
  logic [7:0]  r1_q;
  logic [31:0] data_q;
  logic [7:0]  tx_q;
  logic        en_q;
  logic        cs_q;

  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Timeout     = to_q;
  assign bus.RespR1      = r1_q;
  assign bus.RespData    = data_q;
  assign bus.TxByte      = tx_q;
  assign bus.SpiEnable   = en_q;
  assign bus.SpiEnableCS = cs_q;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v
  );
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge MasterCLK or negedge MasterRST_n) begin
    if (!MasterRST_n) begin
      sync_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.ByteStrobe;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      strobe_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~strobe_q;

  always_comb begin
    cmd_byte = {crc_q, 1'b1};
    case (cnt_q)
      4'd0:    cmd_byte = {2'b01, idx_q};
      4'd1:    cmd_byte = arg_q[31:24];
      4'd2:    cmd_byte = arg_q[23:16];
      4'd3:    cmd_byte = arg_q[15:8];
      4'd4:    cmd_byte = arg_q[7:0];
      default: cmd_byte = {crc_q, 1'b1};
    endcase
  end

  // tag0 labels the slot driven at this tick, tag1 the slot
  // whose received byte is on RxByte at this tick.
  always_ff @(posedge MasterCLK or negedge MasterRST_n) begin
    if (!MasterRST_n) begin
      state_q <= IDLE;
      tag0_q  <= TAG_NONE;
      tag1_q  <= TAG_NONE;
      idx_q   <= '0;
      arg_q   <= '0;
      crc_q   <= '0;
      nresp_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      r1_q    <= 8'hFF;
      data_q  <= '0;
      tx_q    <= 8'hFF;
      en_q    <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tick) begin
        tag1_q <= tag0_q;
        tag0_q <= TAG_NONE;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.Start || bus.InitReq) begin
            busy_q <= 1'b1;
            to_q   <= 1'b0;
            r1_q   <= 8'hFF;
            data_q <= '0;
            cnt_q  <= '0;
          end
          if (bus.Start) begin
            idx_q   <= bus.CmdIndex;
            arg_q   <= bus.CmdArg;
            crc_q   <= bus.CmdCrc;
            nresp_q <= (bus.RespBytes > 3'd4)
                       ? 3'd4 : bus.RespBytes;
            state_q <= PRE;
          end else if (bus.InitReq) begin
            state_q <= INIT;
          end
        end
        INIT: if (tick) begin
          tx_q <= 8'hFF;
          cs_q <= 1'b0;
          en_q <= 1'b1;
          if (cnt_q == 4'(INIT_BYTES - 1))
            state_q <= POST_INIT;
          else
            cnt_q <= sat_inc(cnt_q);
        end
        POST_INIT: if (tick) begin
          en_q    <= 1'b0;
          state_q <= DONE;
        end
        PRE: if (tick) begin
          tx_q    <= 8'hFF;
          cs_q    <= 1'b1;
          en_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= CMD;
        end
        CMD: if (tick) begin
          tx_q <= cmd_byte;
          if (cnt_q == 4'd5) begin
            cnt_q   <= '0;
            state_q <= POLL;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        POLL: if (tick) begin
          tx_q <= 8'hFF;
          if (tag1_q == TAG_POLL && !bus.RxByte[7]) begin
            r1_q  <= bus.RxByte;
            cnt_q <= '0;
            if (nresp_q != 3'd0) begin
              // the already-issued follow-on slot carries data
              tag1_q  <= TAG_DATA;
              tag0_q  <= TAG_DATA;
              state_q <= DATA;
            end else begin
              cs_q    <= 1'b0;
              state_q <= POST;
            end
          end else if (tag1_q == TAG_POLL &&
                       cnt_q == 4'(NCR_MAX - 1)) begin
            to_q    <= 1'b1;
            r1_q    <= 8'hFF;
            cs_q    <= 1'b0;
            state_q <= POST;
          end else begin
            tag0_q <= TAG_POLL;
            if (tag1_q == TAG_POLL)
              cnt_q <= sat_inc(cnt_q);
          end
        end
        DATA: if (tick) begin
          tx_q <= 8'hFF;
          if (tag1_q == TAG_DATA) begin
            data_q <= {data_q[23:0], bus.RxByte};
            if (cnt_q == {1'b0, nresp_q} - 4'd1) begin
              cs_q    <= 1'b0;
              state_q <= POST;
            end else begin
              cnt_q  <= sat_inc(cnt_q);
              tag0_q <= TAG_DATA;
            end
          end else begin
            tag0_q <= TAG_DATA;
          end
        end
        POST: if (tick) begin
          en_q    <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: engine + card model with slot and Done
// scoreboards for sd_cmd_sequencer.
`timescale 1ns/1ps
module tb_sd_cmd_sequencer;

  typedef struct packed {
    logic       cs;
    logic [7:0] tx;
  } slot_t;

  typedef struct packed {
    logic        to;
    logic [7:0]  r1;
    logic [31:0] data;
  } done_t;

  logic MasterCLK = 1'b0;
  logic MasterRST_n = 1'b0;

  sd_cmd_sequencer_if bus();

  sd_cmd_sequencer dut (
    .MasterCLK  (MasterCLK),
    .MasterRST_n(MasterRST_n),
    .bus        (bus)
  );

  always #5 MasterCLK = ~MasterCLK;

  initial begin
    bus.ByteStrobe = 1'b0;
    forever #85 bus.ByteStrobe = ~bus.ByteStrobe;
  end

  int nvec = 0;
  int nmis = 0;
  int done_cnt = 0;

  slot_t exp_slot[$];
  done_t exp_done[$];

  logic       lat_en = 1'b0;
  logic       lat_cs = 1'b0;
  logic [7:0] lat_tx = 8'hFF;
  logic [7:0] cur_out = 8'hFF;
  int         card_cnt = 0;
  bit         armed = 1'b0;
  logic [7:0] card_q[$];

  // byte boundary: finish the old slot, latch the new one
  always @(posedge bus.ByteStrobe) begin
    slot_t got;
    slot_t want;
    if (lat_en && lat_cs) begin
      bus.RxByte = cur_out;
      if (!armed && (card_cnt > 0 || lat_tx[7:6] == 2'b01)) begin
        card_cnt++;
        if (card_cnt == 6) armed = 1'b1;
      end
    end else begin
      bus.RxByte = 8'hFF;
      card_cnt = 0;
      armed = 1'b0;
    end
    lat_en = bus.SpiEnable;
    lat_cs = bus.SpiEnableCS;
    lat_tx = bus.TxByte;
    cur_out = 8'hFF;
    if (armed && card_q.size() > 0) cur_out = card_q.pop_front();
    if (lat_en) begin
      got = {lat_cs, lat_tx};
      nvec++;
      if (exp_slot.size() == 0) begin
        nmis++;
        $display("FAIL slot: got cs=%0b tx=%h, required no slot",
                 got.cs, got.tx);
      end else begin
        want = exp_slot.pop_front();
        if (got !== want) begin
          nmis++;
          $display("FAIL slot: got cs=%0b tx=%h, required cs=%0b tx=%h",
                   got.cs, got.tx, want.cs, want.tx);
        end
      end
    end
  end

  always @(negedge MasterCLK) begin
    done_t want;
    if (MasterRST_n && bus.Done === 1'b1) begin
      done_cnt++;
      nvec++;
      if (exp_done.size() == 0) begin
        nmis++;
        $display("FAIL done: got unexpected Done pulse, required none");
      end else begin
        want = exp_done.pop_front();
        if ({bus.Busy, bus.Timeout, bus.RespR1, bus.RespData} !==
            {1'b0, want.to, want.r1, want.data}) begin
          nmis++;
          $display("FAIL done: got busy=%0b to=%0b r1=%h data=%h, required busy=0 to=%0b r1=%h data=%h",
                   bus.Busy, bus.Timeout, bus.RespR1, bus.RespData,
                   want.to, want.r1, want.data);
        end
      end
      nvec++;
      if (exp_slot.size() != 0) begin
        nmis++;
        $display("FAIL slots_left: got %0d slots pending, required 0",
                 exp_slot.size());
      end
    end
  end

  task automatic check_reset(input string nm);
    nvec++;
    if ({bus.Busy, bus.Done, bus.Timeout, bus.RespR1, bus.RespData,
         bus.TxByte, bus.SpiEnable, bus.SpiEnableCS} !==
        {1'b0, 1'b0, 1'b0, 8'hFF, 32'h0, 8'hFF, 1'b0, 1'b0}) begin
      nmis++;
      $display("FAIL %s: got busy=%0b done=%0b to=%0b r1=%h data=%h tx=%h en=%0b cs=%0b, required 0 0 0 ff 0 ff 0 0",
               nm, bus.Busy, bus.Done, bus.Timeout, bus.RespR1,
               bus.RespData, bus.TxByte, bus.SpiEnable, bus.SpiEnableCS);
    end
  endtask

  task automatic check_busy(input string nm);
    nvec++;
    if (bus.Busy !== 1'b1) begin
      nmis++;
      $display("FAIL %s: got busy=%b, required 1", nm, bus.Busy);
    end
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 4000) begin
      @(negedge MasterCLK);
      k++;
    end
    nvec++;
    if (done_cnt < target) begin
      nmis++;
      $display("FAIL done_wait: got %0d dones, required %0d",
               done_cnt, target);
    end
  endtask

  task automatic issue_cmd(
    input logic [5:0]  idx,
    input logic [31:0] arg,
    input logic [6:0]  crc,
    input logic [2:0]  nr,
    input logic [47:0] frame,
    input int          nff,
    input logic        to,
    input logic [7:0]  r1,
    input logic [31:0] data,
    input bit          with_init
  );
    exp_slot.push_back({1'b1, 8'hFF});
    for (int i = 0; i < 6; i++)
      exp_slot.push_back({1'b1, frame[47-8*i -: 8]});
    for (int i = 0; i < nff; i++)
      exp_slot.push_back({1'b1, 8'hFF});
    exp_slot.push_back({1'b0, 8'hFF});
    exp_done.push_back({to, r1, data});
    @(negedge MasterCLK);
    bus.Start = 1'b1;
    bus.InitReq = with_init;
    bus.CmdIndex = idx;
    bus.CmdArg = arg;
    bus.CmdCrc = crc;
    bus.RespBytes = nr;
    @(negedge MasterCLK);
    bus.Start = 1'b0;
    bus.InitReq = 1'b0;
    check_busy("busy_cmd");
  endtask

  initial begin
    int k;
    bus.Start = 1'b0;
    bus.InitReq = 1'b0;
    bus.CmdIndex = '0;
    bus.CmdArg = '0;
    bus.CmdCrc = '0;
    bus.RespBytes = '0;
    bus.RxByte = 8'hFF;
    repeat (3) @(negedge MasterCLK);
    check_reset("reset");
    MasterRST_n = 1'b1;
    repeat (5) @(negedge MasterCLK);

    // init burst
    for (int i = 0; i < 10; i++) exp_slot.push_back({1'b0, 8'hFF});
    exp_done.push_back({1'b0, 8'hFF, 32'h0});
    bus.InitReq = 1'b1;
    @(negedge MasterCLK);
    bus.InitReq = 1'b0;
    check_busy("busy_init");
    wait_done(1);

    // CMD0, R1 after two idle bytes
    card_q = '{8'hFF, 8'hFF, 8'h01};
    issue_cmd(6'd0, 32'h0, 7'h4A, 3'd0, 48'h400000000095,
              4, 1'b0, 8'h01, 32'h0, 1'b0);
    wait_done(2);

    // CMD8 with R7 tail
    card_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    issue_cmd(6'd8, 32'h1AA, 7'h43, 3'd4, 48'h48000001AA87,
              6, 1'b0, 8'h01, 32'h000001AA, 1'b0);
    wait_done(3);

    // CMD58 with a silent card
    card_q = {};
    issue_cmd(6'd58, 32'h0, 7'h7E, 3'd4, 48'h7A00000000FD,
              9, 1'b1, 8'hFF, 32'h0, 1'b0);
    wait_done(4);

    // R1 on the last allowed poll byte, one trailing byte
    card_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'h00, 8'h5A};
    issue_cmd(6'd16, 32'h200, 7'h0A, 3'd1, 48'h500000020015,
              10, 1'b0, 8'h00, 32'h0000005A, 1'b0);
    wait_done(5);

    // RespBytes above 4 is treated as 4
    card_q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11};
    issue_cmd(6'd8, 32'h1AA, 7'h43, 3'd7, 48'h48000001AA87,
              6, 1'b0, 8'h01, 32'hDEADBEEF, 1'b0);
    wait_done(6);

    // Start+InitReq together, then requests while busy
    card_q = '{8'hFF, 8'h05};
    issue_cmd(6'd55, 32'h0, 7'h32, 3'd0, 48'h770000000065,
              3, 1'b0, 8'h05, 32'h0, 1'b1);
    repeat (40) @(negedge MasterCLK);
    bus.Start = 1'b1;
    bus.InitReq = 1'b1;
    bus.CmdIndex = 6'h11;
    bus.CmdArg = 32'hFFFF_0000;
    bus.RespBytes = 3'd2;
    @(negedge MasterCLK);
    bus.Start = 1'b0;
    bus.InitReq = 1'b0;
    repeat (100) @(negedge MasterCLK);
    bus.Start = 1'b1;
    @(negedge MasterCLK);
    bus.Start = 1'b0;
    wait_done(7);
    repeat (400) @(negedge MasterCLK);
    nvec++;
    if (done_cnt != 7) begin
      nmis++;
      $display("FAIL single_done: got %0d dones, required 7", done_cnt);
    end

    // reset while the third command byte is on TxByte
    card_q = '{8'h01};
    issue_cmd(6'd17, 32'h12345678, 7'h2A, 3'd0, 48'h511234567855,
              2, 1'b0, 8'h01, 32'h0, 1'b0);
    k = 0;
    while (bus.TxByte !== 8'h34 && k < 2000) begin
      @(posedge MasterCLK);
      #1;
      k++;
    end
    nvec++;
    if (bus.TxByte !== 8'h34) begin
      nmis++;
      $display("FAIL cmd_byte3: got tx=%h, required 34", bus.TxByte);
    end
    #1 MasterRST_n = 1'b0;
    #1 check_reset("async_reset");
    exp_slot = {};
    exp_done = {};
    card_q = {};
    repeat (5) @(negedge MasterCLK);
    check_reset("reset_hold");
    MasterRST_n = 1'b1;
    repeat (400) @(negedge MasterCLK);

    // normal command after the abandoned one
    card_q = '{8'hFF, 8'hFF, 8'h01};
    issue_cmd(6'd0, 32'h0, 7'h4A, 3'd0, 48'h400000000095,
              4, 1'b0, 8'h01, 32'h0, 1'b0);
    wait_done(8);
    repeat (50) @(negedge MasterCLK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
